// File: rtl/skolem_sweep_checker_pkg.sv
// Shared definitions for the Skolem sweep checker: controller states and default context width.
package skolem_chk_pkg;

   localparam int N_DEFAULT = 7;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      Q0   = 3'd1,
      Q1   = 3'd2,
      QS   = 3'd3,
      FIN  = 3'd4
   } chk_state_t;

endpackage

// File: rtl/skolem_ctx_judge.sv
// Per-context verdict: a context fails when some output value satisfies the formula
// but the Skolem cell's choice does not.
module skolem_ctx_judge (
   input  logic i_p0,
   input  logic i_p1,
   input  logic i_ps,
   output logic o_fail
);

   logic w_sat;

   // Unsatisfiable contexts (p0 = p1 = 0) place no demand on the cell.
   assign w_sat  = i_p0 | i_p1;
   assign o_fail = w_sat & ~i_ps;

endmodule

// File: rtl/skolem_sweep_checker.sv
// Exhaustive checker: walks every context, probes the oracle with y=0, y=1 and y=sk,
// and accumulates failure count plus the lowest failing context.
module skolem_sweep_checker
   import skolem_chk_pkg::*;
#(
   parameter int N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic [N-1:0] ctx,
   input  logic         sk,
   output logic         y,
   input  logic         phi,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [N:0]   fail_cnt,
   output logic [N-1:0] first_fail_ctx,
   output logic         first_fail_vld
);

   localparam logic [N-1:0] CTX_LAST = '1;
   localparam logic [N-1:0] CTX_ONE  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N:0]   CNT_ONE  = {{N{1'b0}}, 1'b1};

   chk_state_t r_state;
   chk_state_t w_state_next;

   logic [N-1:0] r_ctx;
   logic [N:0]   r_fail_cnt;
   logic [N-1:0] r_first_fail_ctx;
   logic         r_first_fail_vld;
   logic         r_pass;
   logic         r_p0;
   logic         r_p1;
   logic         w_fail;
   logic         w_ctx_last;

   assign w_ctx_last = (r_ctx == CTX_LAST);

   // In QS the oracle sees y=sk, so phi is the verdict on the cell's own choice.
   skolem_ctx_judge u_judge (
      .i_p0   (r_p0),
      .i_p1   (r_p1),
      .i_ps   (phi),
      .o_fail (w_fail)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = Q0;
         Q0:      w_state_next = Q1;
         Q1:      w_state_next = QS;
         QS:      w_state_next = w_ctx_last ? FIN : Q0;
         FIN:     w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      y    = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         Q0:      busy = 1'b1;
         Q1: begin
            busy = 1'b1;
            y    = 1'b1;
         end
         QS: begin
            busy = 1'b1;
            y    = sk;
         end
         FIN: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctx            <= '0;
         r_fail_cnt       <= '0;
         r_first_fail_ctx <= '0;
         r_first_fail_vld <= 1'b0;
         r_pass           <= 1'b0;
         r_p0             <= 1'b0;
         r_p1             <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_ctx            <= '0;
                  r_fail_cnt       <= '0;
                  r_first_fail_ctx <= '0;
                  r_first_fail_vld <= 1'b0;
                  r_pass           <= 1'b0;
               end
            end
            Q0: r_p0 <= phi;
            Q1: r_p1 <= phi;
            QS: begin
               if (w_fail) begin
                  r_fail_cnt <= r_fail_cnt + CNT_ONE;
                  if (!r_first_fail_vld) begin
                     r_first_fail_ctx <= r_ctx;
                     r_first_fail_vld <= 1'b1;
                  end
               end
               if (!w_ctx_last) begin
                  r_ctx <= r_ctx + CTX_ONE;
               end
            end
            FIN: begin
               // The last context's verdict landed in r_fail_cnt on the QS->FIN edge.
               r_pass <= (r_fail_cnt == '0);
               r_ctx  <= '0;
            end
            default: ;
         endcase
      end
   end

   assign ctx            = r_ctx;
   assign fail_cnt       = r_fail_cnt;
   assign first_fail_ctx = r_first_fail_ctx;
   assign first_fail_vld = r_first_fail_vld;
   assign pass           = r_pass;

endmodule

// File: doc/skolem_sweep_checker.md
SKOLEM_SWEEP_CHECKER -- requirements
Module: skolem_sweep_checker

Interface
REQ-001 SHALL have parameter N, default 7, the number of context inputs of the Skolem cell under check.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request one full sweep; sampled only in IDLE.
REQ-005 SHALL have port ctx  output  N  context vector driven to the Skolem cell and the oracle (bit k maps to cell input ik).
REQ-006 SHALL have port sk  input  1  combinational Skolem cell output for the current ctx.
REQ-007 SHALL have port y  output  1  candidate output value presented to the oracle.
REQ-008 SHALL have port phi  input  1  combinational oracle: 1 when formula(ctx, y) holds.
REQ-009 SHALL have port busy  output  1  high while a sweep is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse at sweep completion.
REQ-011 SHALL have port pass  output  1  1 when the last sweep found zero failures.
REQ-012 SHALL have port fail_cnt  output  N+1  number of failing contexts in the last sweep.
REQ-013 SHALL have port first_fail_ctx  output  N  lowest failing context of the last sweep.
REQ-014 SHALL have port first_fail_vld  output  1  first_fail_ctx is meaningful.

Function
REQ-015 SHALL implement the FSM states IDLE, Q0, Q1, QS and FIN.
REQ-016 SHALL move from IDLE to Q0 on start=1, set ctx=0 and clear fail_cnt, pass, first_fail_vld and first_fail_ctx.
REQ-017 SHALL drive y=0 in Q0 and capture phi as p0.
REQ-018 SHALL drive y=1 in Q1 and capture phi as p1.
REQ-019 SHALL drive y=sk in QS (sk sampled in the same cycle) and evaluate phi as ps.
REQ-020 SHALL hold ctx constant across Q0, Q1 and QS of one context; each state lasts exactly one cycle.
REQ-021 SHALL declare the context failing when (p0 | p1) & ~ps; a context with p0=p1=0 (unsatisfiable) never fails.
REQ-022 SHALL, on a failing context, increment fail_cnt; if first_fail_vld=0 it SHALL also load first_fail_ctx=ctx and set first_fail_vld.
REQ-023 SHALL go from QS to Q0 with ctx+1 when ctx < 2^N-1, otherwise to FIN; ctx SHALL never wrap during a sweep.
REQ-024 SHALL in FIN pulse done for one cycle, set pass=(fail_cnt==0) including the last context's verdict, and return to IDLE.
REQ-025 SHALL assert busy in Q0, Q1, QS and FIN, so that busy is high for exactly 3*2^N+1 cycles per sweep.
REQ-026 SHALL ignore start while busy and SHALL NOT queue it.
REQ-027 SHALL hold fail_cnt, pass and first_fail_* stable from done until the next accepted start.
REQ-028 SHALL let fail_cnt reach 2^N without overflow (width N+1); no saturation logic is needed.
REQ-029 SHALL drive ctx=0 and y=0 in IDLE.

Reset
REQ-030 SHALL, while rst=1, force IDLE, ctx=0, y=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail_ctx=0 and first_fail_vld=0.
REQ-031 SHALL abandon any sweep in progress when rst is asserted mid-sweep, producing no done pulse and leaving no partial results.
REQ-032 SHALL ignore start when it is high in the same cycle as rst; the first start is accepted in the cycle after rst deasserts.

Structure
REQ-033 SHALL take the FSM state enum and the default N from package skolem_chk_pkg.
REQ-034 SHALL implement the per-context verdict (p0, p1, ps -> fail) in sub-module skolem_ctx_judge; the counters and FSM SHALL stay in the top module.
REQ-035 SHALL contain no combinational path from sk or phi to any output other than y.

Verification
REQ-036 SHALL cover: N=7, phi=(y==ctx[0]), sk=ctx[0], one start -> done after 385 busy cycles, pass=1, fail_cnt=0, first_fail_vld=0.
REQ-037 SHALL cover: same oracle, sk=~ctx[0] -> pass=0, fail_cnt=128, first_fail_ctx=0x00, first_fail_vld=1.
REQ-038 SHALL cover: phi=0 constantly, sk random -> pass=1, fail_cnt=0.
REQ-039 SHALL cover: phi=(y==ctx[0]) except ctx=0x55 and ctx=0x70 where phi=~(y==sk) -> fail_cnt=2, first_fail_ctx=0x55.
REQ-040 SHALL cover: rst pulsed while ctx=40, then start -> no done before the restart; the new sweep begins at ctx=0 with cleared counts and ends with a correct result.
REQ-041 SHALL cover: start held high for the whole sweep -> exactly one done per 385+1 cycles, and no start is accepted while busy=1.
